ag_stage_ctrl: RTL and testbench

Pipeline controller for the address-generation (AG) stage latch. It generates the latch hold and bubble-injection controls, back-pressures the decode stage, and qualifies the valid seen by the memory stage. It also sequences instructions that need two memory accesses (addr1 then addr2) by holding the latch for a second cycle. It sits between decode, the AG latch, the register scoreboard and the memory stage, and keeps a saturating AG-stall performance counter.

---
 rtl/ag_stage_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ag_stage_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ag_stage_ctrl.sv
// ----------------------------------------------------------------------------
// ag_stage_ctrl
//
// Pipeline controller for the address-generation (AG) stage latch.
//
// This block does four things:
//   * It produces the AG latch hold (ag_stall) and the bubble-injection
//     control (ag_bubble).
//   * It back-pressures decode (dec_stall).
//   * It qualifies the valid that the memory stage sees (ag_out_v).
//   * It sequences two-access instructions, presenting addr1 first and then
//     addr2, by holding the latch for one extra cycle.
//
// It also keeps a saturating count of AG stall cycles.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst         in   asynchronous active-high reset
//   dec_v       in   decode presents a valid instruction to the latch input
//   ag_v        in   valid bit currently held in the AG latch
//   ag_two_acc  in   latched instruction needs two memory accesses
//   dep_stall   in   scoreboard hazard on the latched instruction's sources
//   mem_stall   in   memory stage cannot accept this cycle
//   flush       in   branch redirect, kill AG and decode contents
//   ag_stall    out  AG latch hold (load enable = ~ag_stall)
//   ag_bubble   out  force latch input valid to 0 on this load
//   dec_stall   out  hold the decode stage (always equal to ag_stall)
//   ag_out_v    out  qualified valid presented to the memory stage
//   acc_sel     out  0 = present addr1, 1 = present addr2
//   stall_cnt   out  saturating count of AG stall cycles (CNT_W bits)
//
// Only the sequencing state and stall_cnt are registered. Every other
// output is a combinational function of the state and the inputs.
// ----------------------------------------------------------------------------
module ag_stage_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_v,
    input  logic             ag_v,
    input  logic             ag_two_acc,
    input  logic             dep_stall,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             ag_stall,
    output logic             ag_bubble,
    output logic             dec_stall,
    output logic             ag_out_v,
    output logic             acc_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic               cnt_inc_s;
    logic               dec_v_unused_s;

    // Saturating increment: once all-ones, the value is held rather than
    // wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // dec_v needs no control action here. When the latch loads freely, a
    // low dec_v already loads an invalid entry on its own.
    assign dec_v_unused_s = dec_v;

    // Next-state and output decode, evaluated in priority order:
    // flush, then empty latch, then dep_stall, then mem_stall, then sequencing.
    always_comb begin
        state_d   = state_q;
        ag_stall  = 1'b0;
        ag_bubble = 1'b0;
        ag_out_v  = 1'b0;
        acc_sel   = 1'b0;

        if (flush) begin
            // The redirect discards any pending second access and loads a bubble.
            ag_bubble = 1'b1;
            state_d   = ST_RUN;
        end else if (!ag_v) begin
            // An empty latch loads freely. Seeing SECOND here is illegal,
            // so the block recovers by returning to RUN.
            state_d   = ST_RUN;
        end else if (dep_stall) begin
            // Sources are not ready, so the instruction is held invisible to
            // memory. acc_sel keeps pointing at the access in progress.
            ag_stall  = 1'b1;
            acc_sel   = (state_q == ST_SECOND) ? 1'b1 : 1'b0;
        end else if (mem_stall) begin
            // The address is presented but not accepted, so it is held
            // without advancing the sequencing.
            ag_stall  = 1'b1;
            ag_out_v  = 1'b1;
            acc_sel   = (state_q == ST_SECOND) ? 1'b1 : 1'b0;
        end else begin
            ag_out_v = 1'b1;
            case (state_q)
                ST_RUN: begin
                    acc_sel = 1'b0;
                    if (ag_two_acc) begin
                        // addr1 goes out now. The latch is held one extra
                        // cycle so that addr2 can follow.
                        ag_stall = 1'b1;
                        state_d  = ST_SECOND;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
                ST_SECOND: begin
                    acc_sel = 1'b1;
                    state_d = ST_RUN;
                end
                default: begin
                    acc_sel = 1'b0;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign dec_stall = ag_stall;

    // A cycle counts as a stall only when a valid, unflushed instruction is
    // held. This includes the planned hold that issues addr1.
    always_comb begin
        cnt_inc_s = ag_v & ~flush & ag_stall;
        if (cnt_inc_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Sequencing state register, with asynchronous reset to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall performance counter, with asynchronous reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ag_stage_ctrl.sv
module tb_ag_stage_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             dec_v;
    logic             ag_v;
    logic             ag_two_acc;
    logic             dep_stall;
    logic             mem_stall;
    logic             flush;
    logic             ag_stall;
    logic             ag_bubble;
    logic             dec_stall;
    logic             ag_out_v;
    logic             acc_sel;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks;
    int n_errors;

    ag_stage_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_v      (dec_v),
        .ag_v       (ag_v),
        .ag_two_acc (ag_two_acc),
        .dep_stall  (dep_stall),
        .mem_stall  (mem_stall),
        .flush      (flush),
        .ag_stall   (ag_stall),
        .ag_bubble  (ag_bubble),
        .dec_stall  (dec_stall),
        .ag_out_v   (ag_out_v),
        .acc_sel    (acc_sel),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dec_v;
        logic        ag_v;
        logic        two;
        logic        dep;
        logic        mem;
        logic        flush;
        logic        e_stall;
        logic        e_bubble;
        logic        e_outv;
        logic        e_acc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic dv, input logic av, input logic tw,
                                input logic dp, input logic mm, input logic fl,
                                input logic es, input logic eb, input logic eo,
                                input logic ea, input logic [15:0] ec);
        vec_t v;
        v.dec_v = dv; v.ag_v = av; v.two = tw; v.dep = dp; v.mem = mm; v.flush = fl;
        v.e_stall = es; v.e_bubble = eb; v.e_outv = eo; v.e_acc = ea; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dv, input logic av, input logic tw,
                         input logic dp, input logic mm, input logic fl);
        dec_v = dv; ag_v = av; ag_two_acc = tw; dep_stall = dp; mem_stall = mm; flush = fl;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //            dv    av    two   dep   mem   fl  | stall bub  outv  acc   cnt
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
        vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd4);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd7);
        vecs[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8);
        vecs[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd8);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
        vecs[16] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9);
        vecs[17] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10);
        vecs[18] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd10);
        vecs[19] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd10);
        vecs[20] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd11);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd11);
        vecs[22] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd11);

        // Reset state, checked mid-cycle while rst is still asserted.
        #12;
        chk("rst_cnt",    32'(stall_cnt), 32'd0);
        chk("rst_stall",  32'(ag_stall),  32'd0);
        chk("rst_bubble", 32'(ag_bubble), 32'd0);
        chk("rst_outv",   32'(ag_out_v),  32'd0);
        chk("rst_acc",    32'(acc_sel),   32'd0);
        chk("rst_dstall", 32'(dec_stall), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: one row per cycle. Combinational outputs are checked
        // mid-cycle, and the counter is checked just after the clock edge.
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].dec_v, vecs[i].ag_v, vecs[i].two,
                  vecs[i].dep, vecs[i].mem, vecs[i].flush);
            #2;
            chk($sformatf("v%0d_stall", i),  32'(ag_stall),  32'(vecs[i].e_stall));
            chk($sformatf("v%0d_dstall", i), 32'(dec_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_bubble", i), 32'(ag_bubble), 32'(vecs[i].e_bubble));
            chk($sformatf("v%0d_outv", i),   32'(ag_out_v),  32'(vecs[i].e_outv));
            chk($sformatf("v%0d_acc", i),    32'(acc_sel),   32'(vecs[i].e_acc));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i),    32'(stall_cnt), 32'(vecs[i].e_cnt));
        end

        // Sequence: asynchronous reset while in SECOND. The block must return
        // to RUN (acc_sel=0) before any clock edge.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("ar_cnt_pre", 32'(stall_cnt), 32'd12);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("ar_acc_pre", 32'(acc_sel), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_acc_post",  32'(acc_sel),   32'd0);
        chk("ar_outv_post", 32'(ag_out_v),  32'd1);
        chk("ar_cnt_post",  32'(stall_cnt), 32'd0);
        #2;
        rst = 1'b0;

        // Sequence: a held dependency stall drives the counter up to
        // saturation. Counting starts from zero after the reset above.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("sat_first", 32'(stall_cnt), 32'd1);
        for (int k = 1; k < 65534; k++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        @(posedge clk);
        #1;
        chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        for (int k = 0; k < 4400; k++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_hold",  32'(stall_cnt), 32'hFFFF);
        chk("sat_stall", 32'(ag_stall),  32'd1);
        chk("sat_outv",  32'(ag_out_v),  32'd0);

        // Asynchronous reset pulse mid-cycle clears the counter immediately.
        #1;
        rst = 1'b1;
        #1;
        chk("sat_rst_cnt", 32'(stall_cnt), 32'd0);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("post_idle_cnt", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
